// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// delivers the returned word into the IF/ID pipeline register, and
// supplies the sequential next PC to the PC unit.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no request outstanding; capture PC as the next fetch address
// REQ   | request outstanding on reqAddr, waiting for IMemAck
// KILL  | flushed while a request was outstanding; drain and drop its ack
// HOLD  | word returned while decode stalled; parked in holdInstr
module if_fetch_stage #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [31:0]      PC,
    input  logic             Stall,
    input  logic             Flush,
    output logic             IMemReq,
    output logic [31:0]      IMemAddr,
    input  logic             IMemAck,
    input  logic [31:0]      IMemData,
    output logic [31:0]      nextPC,
    output logic [31:0]      IF_ID_Instr,
    output logic [31:0]      IF_ID_PC4,
    output logic             IF_ID_Valid,
    output logic [CNT_W-1:0] FetchCnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2,
        HOLD = 2'd3
    } fetchState_t;

    fetchState_t      state;
    fetchState_t      stateNext;
    logic [31:0]      reqAddr;
    logic [31:0]      reqAddrNext;
    logic [31:0]      reqAddrPlus4;
    logic [31:0]      holdInstr;
    logic [31:0]      holdInstrNext;
    logic [31:0]      instrNext;
    logic [31:0]      pc4Next;
    logic             validNext;
    logic [CNT_W-1:0] cntNext;
    logic             advance;

    // Address arithmetic is plain 32-bit modular; 0xFFFF_FFFC wraps to 0.
    assign reqAddrPlus4 = reqAddr + 32'd4;
    assign IMemAddr     = reqAddr;

    // Request and next-PC outputs are gated by Reset so a reset cycle never
    // issues a request or redirects the PC unit.
    assign IMemReq = !Reset && ((state == REQ) || (state == KILL));
    assign nextPC  = (advance && !Reset) ? reqAddrPlus4 : PC;

    // Next-state and next-register values; every register holds by default.
    always_comb begin
        stateNext     = state;
        reqAddrNext   = reqAddr;
        holdInstrNext = holdInstr;
        instrNext     = IF_ID_Instr;
        pc4Next       = IF_ID_PC4;
        validNext     = IF_ID_Valid;
        cntNext       = FetchCnt;
        advance       = 1'b0;

        case (state)
            IDLE: begin
                reqAddrNext = PC;
                stateNext   = REQ;
                if (Flush) begin
                    validNext = 1'b0;
                end
            end
            REQ: begin
                if (IMemAck) begin
                    if (Flush) begin
                        validNext = 1'b0;
                        stateNext = IDLE;
                    end else if (Stall) begin
                        holdInstrNext = IMemData;
                        stateNext     = HOLD;
                    end else begin
                        advance   = 1'b1;
                        instrNext = IMemData;
                    end
                end else begin
                    // On a flush the outstanding request keeps its address so
                    // the memory sees a stable request until it acks.
                    if (Flush) begin
                        validNext = 1'b0;
                        stateNext = KILL;
                    end else if (!Stall) begin
                        validNext = 1'b0;
                    end
                end
            end
            KILL: begin
                if (Flush) begin
                    validNext = 1'b0;
                end
                if (IMemAck) begin
                    stateNext = IDLE;
                end
            end
            HOLD: begin
                if (Flush) begin
                    validNext = 1'b0;
                    stateNext = IDLE;
                end else if (!Stall) begin
                    advance   = 1'b1;
                    instrNext = holdInstr;
                    stateNext = REQ;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (advance) begin
            pc4Next     = reqAddrPlus4;
            validNext   = 1'b1;
            cntNext     = FetchCnt + 1'b1;
            reqAddrNext = reqAddrPlus4;
        end
    end

    // State register and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            reqAddr     <= 32'd0;
            holdInstr   <= 32'd0;
            IF_ID_Instr <= 32'd0;
            IF_ID_PC4   <= 32'd0;
            IF_ID_Valid <= 1'b0;
            FetchCnt    <= '0;
        end else begin
            state       <= stateNext;
            reqAddr     <= reqAddrNext;
            holdInstr   <= holdInstrNext;
            IF_ID_Instr <= instrNext;
            IF_ID_PC4   <= pc4Next;
            IF_ID_Valid <= validNext;
            FetchCnt    <= cntNext;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage with hand-computed expectations.
module tb_if_fetch_stage;

    logic        Clk;
    logic        Reset;
    logic [31:0] PC;
    logic        Stall;
    logic        Flush;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic [31:0] nextPC;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PC4;
    logic        IF_ID_Valid;
    logic [15:0] FetchCnt;

    int checks = 0;
    int errors = 0;

    if_fetch_stage #(.CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .PC(PC), .Stall(Stall), .Flush(Flush),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck),
        .IMemData(IMemData), .nextPC(nextPC), .IF_ID_Instr(IF_ID_Instr),
        .IF_ID_PC4(IF_ID_PC4), .IF_ID_Valid(IF_ID_Valid), .FetchCnt(FetchCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; PC = 32'h3000; Stall = 1'b0; Flush = 1'b0;
        IMemAck = 1'b0; IMemData = 32'h0;
        tick();
        tick();
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", IMemReq); end
        checks++; if (nextPC !== 32'h3000) begin errors++; $display("FAIL reset_nextpc got %h exp 00003000", nextPC); end
        checks++; if (IMemAddr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", IMemAddr); end
        checks++; if (IF_ID_Instr !== 32'h0 || IF_ID_PC4 !== 32'h0) begin errors++; $display("FAIL reset_ifid got %h/%h exp 0/0", IF_ID_Instr, IF_ID_PC4); end
        checks++; if (IF_ID_Valid !== 1'b0 || FetchCnt !== 16'h0) begin errors++; $display("FAIL reset_valid_cnt got %b/%h exp 0/0", IF_ID_Valid, FetchCnt); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h3000) begin errors++; $display("FAIL fetch_req got %b/%h exp 1/00003000", IMemReq, IMemAddr); end
        IMemAck = 1'b1; IMemData = 32'h2001_0005;
        #1;
        checks++; if (nextPC !== 32'h3004) begin errors++; $display("FAIL fetch_nextpc got %h exp 00003004", nextPC); end
        tick();
        IMemAck = 1'b0;
        checks++; if (IF_ID_Instr !== 32'h2001_0005 || IF_ID_PC4 !== 32'h3004) begin errors++; $display("FAIL fetch_ifid got %h/%h exp 20010005/00003004", IF_ID_Instr, IF_ID_PC4); end
        checks++; if (IF_ID_Valid !== 1'b1 || FetchCnt !== 16'd1) begin errors++; $display("FAIL fetch_valid_cnt got %b/%h exp 1/0001", IF_ID_Valid, FetchCnt); end
        checks++; if (IMemAddr !== 32'h3004) begin errors++; $display("FAIL fetch_addr2 got %h exp 00003004", IMemAddr); end
        // Stall with no ack: IF/ID holds.
        Stall = 1'b1;
        tick();
        checks++; if (IF_ID_Valid !== 1'b1 || IMemAddr !== 32'h3004) begin errors++; $display("FAIL stall_noack got %b/%h exp 1/00003004", IF_ID_Valid, IMemAddr); end
        // No stall, no ack: bubble.
        Stall = 1'b0;
        tick();
        checks++; if (IF_ID_Valid !== 1'b0 || IMemAddr !== 32'h3004) begin errors++; $display("FAIL bubble got %b/%h exp 0/00003004", IF_ID_Valid, IMemAddr); end
        IMemAck = 1'b1; IMemData = 32'h1111_1111;
        tick();
        IMemAck = 1'b0;
        checks++; if (IF_ID_Instr !== 32'h1111_1111 || IF_ID_PC4 !== 32'h3008 || FetchCnt !== 16'd2) begin errors++; $display("FAIL fetch2 got %h/%h/%h exp 11111111/00003008/0002", IF_ID_Instr, IF_ID_PC4, FetchCnt); end
    endtask

    task automatic test_kill();
        Flush = 1'b1; PC = 32'h3040;
        tick();
        Flush = 1'b0;
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h3008 || IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL kill_enter got %b/%h/%b exp 1/00003008/0", IMemReq, IMemAddr, IF_ID_Valid); end
        tick();
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h3008) begin errors++; $display("FAIL kill_wait got %b/%h exp 1/00003008", IMemReq, IMemAddr); end
        IMemAck = 1'b1; IMemData = 32'hDEAD_BEEF; Stall = 1'b1;
        tick();
        IMemAck = 1'b0; Stall = 1'b0;
        checks++; if (IMemReq !== 1'b0 || IF_ID_Instr !== 32'h1111_1111 || IF_ID_Valid !== 1'b0 || FetchCnt !== 16'd2) begin errors++; $display("FAIL kill_drop got %b/%h/%b/%h exp 0/11111111/0/0002", IMemReq, IF_ID_Instr, IF_ID_Valid, FetchCnt); end
        tick();
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h3040) begin errors++; $display("FAIL kill_newpc got %b/%h exp 1/00003040", IMemReq, IMemAddr); end
    endtask

    task automatic test_hold();
        // Redirect with an ack in the same cycle: data dropped, back to IDLE.
        Flush = 1'b1; IMemAck = 1'b1; IMemData = 32'h0BAD_0BAD; PC = 32'h300C;
        tick();
        Flush = 1'b0; IMemAck = 1'b0;
        checks++; if (IMemReq !== 1'b0 || IF_ID_Valid !== 1'b0 || FetchCnt !== 16'd2) begin errors++; $display("FAIL flush_ack got %b/%b/%h exp 0/0/0002", IMemReq, IF_ID_Valid, FetchCnt); end
        tick();
        checks++; if (IMemAddr !== 32'h300C) begin errors++; $display("FAIL hold_req got %h exp 0000300c", IMemAddr); end
        IMemAck = 1'b1; IMemData = 32'hCAFE_0001; Stall = 1'b1;
        tick();
        IMemAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (IMemReq !== 1'b0 || nextPC !== 32'h300C || IF_ID_Instr !== 32'h1111_1111) begin errors++; $display("FAIL hold_cycle%0d got %b/%h/%h exp 0/0000300c/11111111", i, IMemReq, nextPC, IF_ID_Instr); end
            if (i < 2) tick();
        end
        Stall = 1'b0;
        #1;
        checks++; if (nextPC !== 32'h3010) begin errors++; $display("FAIL hold_nextpc got %h exp 00003010", nextPC); end
        tick();
        checks++; if (IF_ID_Instr !== 32'hCAFE_0001 || IF_ID_PC4 !== 32'h3010 || IF_ID_Valid !== 1'b1 || FetchCnt !== 16'd3) begin errors++; $display("FAIL hold_release got %h/%h/%b/%h exp cafe0001/00003010/1/0003", IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, FetchCnt); end
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h3010) begin errors++; $display("FAIL hold_nextreq got %b/%h exp 1/00003010", IMemReq, IMemAddr); end
    endtask

    task automatic test_stall_flush();
        PC = 32'h4000; Stall = 1'b1; Flush = 1'b1; IMemAck = 1'b1; IMemData = 32'h0000_0BAD;
        #1;
        checks++; if (nextPC !== 32'h4000) begin errors++; $display("FAIL sf_nextpc got %h exp 00004000", nextPC); end
        tick();
        Stall = 1'b0; Flush = 1'b0; IMemAck = 1'b0;
        checks++; if (IF_ID_Valid !== 1'b0 || IMemReq !== 1'b0 || IF_ID_Instr !== 32'hCAFE_0001 || FetchCnt !== 16'd3) begin errors++; $display("FAIL sf_drop got %b/%b/%h/%h exp 0/0/cafe0001/0003", IF_ID_Valid, IMemReq, IF_ID_Instr, FetchCnt); end
    endtask

    task automatic test_back_to_back_wrap();
        // 65532 back-to-back advances take FetchCnt from 3 to 0xFFFF; the start
        // address is chosen so the following advance is the one at 0xFFFF_FFFC.
        PC = 32'hFFFC_000C;
        tick();
        IMemAck = 1'b1; IMemData = 32'h0000_0013;
        for (int i = 0; i < 65532; i++) tick();
        checks++; if (FetchCnt !== 16'hFFFF || IMemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL b2b_preset got %h/%h exp ffff/fffffffc", FetchCnt, IMemAddr); end
        checks++; if (nextPC !== 32'h0) begin errors++; $display("FAIL wrap_nextpc got %h exp 0", nextPC); end
        tick();
        IMemAck = 1'b0;
        checks++; if (FetchCnt !== 16'h0 || IF_ID_PC4 !== 32'h0 || IMemAddr !== 32'h0 || IF_ID_Instr !== 32'h13) begin errors++; $display("FAIL wrap got %h/%h/%h/%h exp 0000/0/0/13", FetchCnt, IF_ID_PC4, IMemAddr, IF_ID_Instr); end
    endtask

    task automatic test_reset_mid();
        // Request outstanding on address 0 with no ack for several cycles.
        tick();
        tick();
        PC = 32'h5000; Reset = 1'b1; Stall = 1'b1;
        #1;
        checks++; if (IMemReq !== 1'b0 || nextPC !== 32'h5000) begin errors++; $display("FAIL rst_comb got %b/%h exp 0/00005000", IMemReq, nextPC); end
        tick();
        Reset = 1'b0; Stall = 1'b0;
        checks++; if (IF_ID_Instr !== 32'h0 || IF_ID_PC4 !== 32'h0 || IF_ID_Valid !== 1'b0 || FetchCnt !== 16'h0 || IMemAddr !== 32'h0 || IMemReq !== 1'b0) begin errors++; $display("FAIL rst_mid got %h/%h/%b/%h/%h/%b exp all zero", IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, FetchCnt, IMemAddr, IMemReq); end
        IMemAck = 1'b1; IMemData = 32'h0000_0077;
        tick();
        IMemAck = 1'b0;
        checks++; if (IF_ID_Valid !== 1'b0 || FetchCnt !== 16'h0 || IMemAddr !== 32'h5000 || IMemReq !== 1'b1) begin errors++; $display("FAIL rst_stale_ack got %b/%h/%h/%b exp 0/0000/00005000/1", IF_ID_Valid, FetchCnt, IMemAddr, IMemReq); end
        IMemAck = 1'b1; IMemData = 32'h0000_0055;
        tick();
        IMemAck = 1'b0;
        checks++; if (IF_ID_Instr !== 32'h55 || IF_ID_PC4 !== 32'h5004 || FetchCnt !== 16'd1) begin errors++; $display("FAIL rst_refetch got %h/%h/%h exp 00000055/00005004/0001", IF_ID_Instr, IF_ID_PC4, FetchCnt); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_kill();
        test_hold();
        test_stall_flush();
        test_back_to_back_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
